// File: rtl/vga_frame_scheduler_pkg.sv
// Shared types and constants for the VGA frame scheduler.
// Covers raster timing, client indices and sequencer states.
package vga_sched_pkg;

  localparam int LAST_ROW_DEF  = 479;
  localparam int H_TOTAL       = 800;
  localparam int V_BLANK_LINES = 45;

  localparam int CL_GROUND = 0;
  localparam int CL_DINO   = 1;
  localparam int CL_CACTUS = 2;
  localparam int CL_SCORE  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_START,
    ST_WAIT,
    ST_DONE
  } sched_st_t;

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Start/done bus between the frame scheduler and its update clients.
// The master is the scheduler; the slave side is the set of clients.
interface vga_sched_if #(
  parameter int N = 4
) ();

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  upd_start;
  logic [N-1:0]  upd_done;
  logic [N-1:0]  client_en;
  logic [IW-1:0] grant_id;

  modport master (
    output upd_start,
    output grant_id,
    input  upd_done,
    input  client_en
  );

  modport slave (
    input  upd_start,
    input  grant_id,
    output upd_done,
    output client_en
  );

endinterface

// File: rtl/vga_frame_scheduler_edge_det.sv
// Frame boundary detector on the raster rdn/row_addr outputs.
// Shared with the sprite renderers.
module vga_frame_edge_det
  import vga_sched_pkg::*;
#(
  parameter int LAST_ROW = LAST_ROW_DEF
) (
  input  logic       vga_clk,
  input  logic       clrn,
  input  logic       i_rdn,
  input  logic [8:0] i_row,
  output logic       o_frame_end,
  output logic       o_frame_start
);

  logic r_rdn_q;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) r_rdn_q <= 1'b1;
    else       r_rdn_q <= i_rdn;
  end

  assign o_frame_end   = !r_rdn_q && i_rdn &&
                         (i_row == 9'(LAST_ROW));
  assign o_frame_start = r_rdn_q && !i_rdn &&
                         (i_row == 9'd0);

endmodule

// File: rtl/vga_frame_scheduler.sv
// Runs per-frame client updates inside vertical blanking.
// Aborts the sequence if active video restarts first.
module vga_frame_scheduler
  import vga_sched_pkg::*;
#(
  parameter  int N_CLIENTS   = 4,
  parameter  int TIMEOUT_CYC = 8192,
  parameter  int LAST_ROW    = LAST_ROW_DEF,
  parameter  int CNT_W       = 16,
  localparam int IW = (N_CLIENTS > 1) ?
                      $clog2(N_CLIENTS) : 1
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic             rdn,
  input  logic [8:0]       row_addr,
  input  logic             run_en,
  input  logic             clr_flags,
  vga_sched_if.master      cl,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun,
  output logic             timeout,
  output logic [IW-1:0]    timeout_id,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IX = IW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam bit FITS =
    (N_CLIENTS * TIMEOUT_CYC) <= (H_TOTAL * V_BLANK_LINES);

  sched_st_t        r_state;
  logic [IX-1:0]    r_idx;
  logic [IW-1:0]    r_grant;
  logic [N_CLIENTS-1:0] r_start;
  logic             r_busy;
  logic [TW-1:0]    r_tcnt;
  logic             r_ovr;
  logic             r_to;
  logic [IW-1:0]    r_toid;
  logic             r_tick;
  logic [CNT_W-1:0] r_cnt;

  logic          w_fend;
  logic          w_fstart;
  logic          w_hit;
  logic [IW-1:0] w_sel;
  logic          w_active;

  vga_frame_edge_det #(
    .LAST_ROW (LAST_ROW)
  ) u_edge (
    .vga_clk       (vga_clk),
    .clrn          (clrn),
    .i_rdn         (rdn),
    .i_row         (row_addr),
    .o_frame_end   (w_fend),
    .o_frame_start (w_fstart)
  );

  // lowest enabled client at or above the cursor
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (cl.client_en[i] && (i >= int'(r_idx))) begin
        w_hit = 1'b1;
        w_sel = IW'(i);
      end
    end
  end

  assign w_active = (r_state == ST_SCAN) ||
                    (r_state == ST_START) ||
                    (r_state == ST_WAIT);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_grant <= '0;
      r_start <= '0;
      r_busy  <= 1'b0;
      r_tcnt  <= '0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
      r_toid  <= '0;
      r_tick  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_tick  <= w_fend;
      r_start <= '0;
      if (w_fend) r_cnt <= r_cnt + CNT_W'(1);
      if (clr_flags) begin
        r_ovr <= 1'b0;
        r_to  <= 1'b0;
      end
      if (w_fstart && w_active) begin
        r_ovr   <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_fend && run_en) begin
              r_idx   <= '0;
              r_state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (w_hit) begin
              r_idx   <= {1'b0, w_sel};
              r_grant <= w_sel;
              r_start <= N_CLIENTS'(1) << w_sel;
              r_busy  <= 1'b1;
              r_tcnt  <= '0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_DONE;
            end
          end
          ST_START: begin
            r_tcnt  <= r_tcnt + TW'(1);
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cl.upd_done[r_grant]) begin
              r_idx   <= r_idx + IX'(1);
              r_state <= ST_SCAN;
            end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
              r_to    <= 1'b1;
              r_toid  <= r_grant;
              r_idx   <= r_idx + IX'(1);
              r_state <= ST_SCAN;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cl.upd_start = r_start;
  assign cl.grant_id  = r_grant;
  assign frame_tick   = r_tick;
  assign busy         = r_busy;
  assign overrun      = r_ovr;
  assign timeout      = r_to;
  assign timeout_id   = r_toid;
  assign frame_cnt    = r_cnt;

  a_budget: assert property (
    @(posedge vga_clk) disable iff (!clrn) FITS);
  a_onehot: assert property (
    @(posedge vga_clk) disable iff (!clrn) $onehot0(r_start));

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler on a shortened raster.
// Expected events are queued by stimulus and popped by a monitor.
module tb_vga_frame_scheduler;
  import vga_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 8;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic          vga_clk   = 1'b0;
  logic          clrn      = 1'b1;
  logic          rdn       = 1'b1;
  logic [8:0]    row_addr  = 9'd0;
  logic          run_en    = 1'b0;
  logic          clr_flags = 1'b0;
  logic          frame_tick, busy, overrun, timeout;
  logic [1:0]    timeout_id;
  logic [CW-1:0] frame_cnt;

  vga_sched_if #(.N(N)) cif ();

  vga_frame_scheduler #(
    .N_CLIENTS   (N),
    .TIMEOUT_CYC (TO),
    .LAST_ROW    (LAST_ROW_DEF),
    .CNT_W       (CW)
  ) dut (
    .vga_clk    (vga_clk),
    .clrn       (clrn),
    .rdn        (rdn),
    .row_addr   (row_addr),
    .run_en     (run_en),
    .clr_flags  (clr_flags),
    .cl         (cif),
    .frame_tick (frame_tick),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout),
    .timeout_id (timeout_id),
    .frame_cnt  (frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  int   lat [N] = '{3, 3, 3, 3};
  exp_t q_start[$];
  exp_t q_tick[$];
  exp_t q_flag[$];
  exp_t q_busy[$];

  task automatic chk(string nm, int got, int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  task automatic cmp(string nm, bit have, exp_t e, int gc, int gv);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s: unexpected cyc=%0d val=0x%0h want none",
               nm, gc, gv);
    end else if (gc != e.cyc || gv != e.val) begin
      bad++;
      $display("FAIL %s: got cyc=%0d val=0x%0h want cyc=%0d val=0x%0h",
               nm, gc, gv, e.cyc, e.val);
    end
  endtask

  // client model: done pulses lat cycles after start; lat=0 never answers
  initial begin
    int cd [N];
    cif.upd_done = '0;
    for (int i = 0; i < N; i++) cd[i] = 0;
    forever begin
      @(negedge vga_clk);
      for (int i = 0; i < N; i++) begin
        if (!clrn) cd[i] = 0;
        if (cd[i] > 0) begin
          cd[i]--;
          cif.upd_done[i] = (cd[i] == 0);
        end else begin
          cif.upd_done[i] = 1'b0;
        end
        if (cif.upd_start[i]) cd[i] = lat[i];
      end
    end
  end

  initial begin
    exp_t e;
    bit   h;
    bit   p_busy, p_ovr, p_to;
    p_busy = 0; p_ovr = 0; p_to = 0;
    forever begin
      @(negedge vga_clk);
      if (!clrn) begin
        p_busy = 0; p_ovr = 0; p_to = 0;
      end else begin
        if (cif.upd_start != '0) begin
          h = q_start.size() > 0;
          if (h) e = q_start.pop_front();
          cmp("start", h, e, cyc,
              int'({cif.grant_id, cif.upd_start}));
        end
        if (frame_tick) begin
          h = q_tick.size() > 0;
          if (h) e = q_tick.pop_front();
          cmp("tick", h, e, cyc, int'(frame_cnt));
        end
        if ((overrun && !p_ovr) || (timeout && !p_to)) begin
          h = q_flag.size() > 0;
          if (h) e = q_flag.pop_front();
          cmp("flag", h, e, cyc,
              int'({overrun, timeout, timeout_id}));
        end
        if (p_busy && !busy) begin
          h = q_busy.size() > 0;
          if (h) e = q_busy.pop_front();
          cmp("busy_fall", h, e, cyc, 0);
        end
        p_busy = busy; p_ovr = overrun; p_to = timeout;
      end
    end
  end

  task automatic push(int k, int c, int v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    case (k)
      0: q_start.push_back(e);
      1: q_tick.push_back(e);
      2: q_flag.push_back(e);
      default: q_busy.push_back(e);
    endcase
  endtask

  task automatic push_start(int c, int i);
    push(0, c, (i << 4) | (1 << i));
  endtask

  task automatic end_frame(output int t);
    @(negedge vga_clk);
    row_addr = 9'd479;
    rdn = 1'b0;
    @(negedge vga_clk);
    rdn = 1'b1;
    t = cyc + 1;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    push(1, t, exp_cnt);
  endtask

  task automatic blank(int n);
    repeat (n) begin
      @(negedge vga_clk);
      row_addr = 9'd480;
      rdn = 1'b1;
    end
  endtask

  task automatic row0();
    @(negedge vga_clk);
    row_addr = 9'd0;
    rdn = 1'b0;
    repeat (3) @(negedge vga_clk);
    rdn = 1'b1;
  endtask

  function automatic int outs();
    return int'({frame_tick, busy, overrun, timeout, timeout_id,
                 frame_cnt, cif.upd_start, cif.grant_id});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: cyc=%0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    cif.client_en = 4'hF;
    #1 clrn = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("reset_outputs", outs(), 0);
    clrn = 1'b1;
    run_en = 1'b1;

    // all four clients, 3-cycle done
    end_frame(t);
    for (int k = 0; k < 4; k++) push_start(t + 1 + 5 * k, k);
    push(3, t + 22, 0);
    blank(30);
    row0();

    // clients 1 and 3 only
    cif.client_en = 4'b1010;
    end_frame(t);
    push_start(t + 1, 1);
    push_start(t + 6, 3);
    push(3, t + 12, 0);
    blank(20);
    row0();

    // cactus client never answers
    cif.client_en = 4'hF;
    lat[CL_CACTUS] = 0;
    end_frame(t);
    push_start(t + 1, CL_GROUND);
    push_start(t + 6, CL_DINO);
    push_start(t + 11, CL_CACTUS);
    push(2, t + 27, 4'b0110);
    push_start(t + 28, CL_SCORE);
    push(3, t + 34, 0);
    blank(36);
    chk("timeout_set", int'(timeout), 1);
    clr_flags = 1'b1;
    @(negedge vga_clk);
    clr_flags = 1'b0;
    chk("timeout_cleared", int'(timeout), 0);
    chk("timeout_id_kept", int'(timeout_id), 2);
    blank(3);
    row0();

    // dino client overruns into next frame
    lat[CL_CACTUS] = 3;
    lat[CL_DINO] = 0;
    end_frame(t);
    push_start(t + 1, 0);
    push_start(t + 6, 1);
    push(2, t + 11, 4'b1010);
    push(3, t + 11, 0);
    blank(10);
    row0();
    chk("overrun_sticky", int'(overrun), 1);
    lat[CL_DINO] = 3;
    end_frame(t);
    for (int k = 0; k < 4; k++) push_start(t + 1 + 5 * k, k);
    push(3, t + 22, 0);
    blank(30);
    row0();

    // paused frames still counted
    run_en = 1'b0;
    repeat (3) begin
      end_frame(t);
      blank(5);
      row0();
    end
    chk("paused_cnt", int'(frame_cnt), 8);

    // reset while a client is granted
    run_en = 1'b1;
    lat[0] = 0;
    end_frame(t);
    push_start(t + 1, 0);
    blank(4);
    chk("busy_in_wait", int'(busy), 1);
    #2 clrn = 1'b0;
    #1 chk("async_reset", outs(), 0);
    exp_cnt = 0;
    repeat (2) @(negedge vga_clk);
    clrn = 1'b1;
    lat[0] = 3;
    blank(2);
    row0();

    // counter wrap
    run_en = 1'b0;
    repeat (256) end_frame(t);
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk("cnt_wrap", int'(frame_cnt), 0);

    // done lands on the last timeout cycle
    blank(2);
    row0();
    run_en = 1'b1;
    cif.client_en = 4'b0001;
    lat[0] = 15;
    end_frame(t);
    push_start(t + 1, 0);
    push(3, t + 19, 0);
    blank(25);
    chk("done_beats_timeout", int'(timeout), 0);
    row0();

    repeat (5) @(negedge vga_clk);
    chk("q_start_left", q_start.size(), 0);
    chk("q_tick_left", q_tick.size(), 0);
    chk("q_flag_left", q_flag.size(), 0);
    chk("q_busy_left", q_busy.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
